// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths and the write-back request type
package rv_core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] wd;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order load-result buffer with kill-by-rd, invalid-head drop and pending bitmap
module wb_fifo import rv_core_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [REG_ADDR_W-1:0]    push_rd,
  input  logic [DATA_WIDTH-1:0]    push_wd,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_ADDR_W-1:0]    kill_rd,
  output logic                     head_valid,
  output logic [REG_ADDR_W-1:0]    head_rd,
  output logic [DATA_WIDTH-1:0]    head_wd,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0] vld;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [DATA_WIDTH-1:0] wd_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic deq;
  assign empty = occupancy == '0;
  assign full = occupancy == CW'(DEPTH);
  assign head_valid = !empty && vld[head];
  assign head_rd = rd_q[head];
  assign head_wd = wd_q[head];
  // a killed head leaves without a write, even while the ALU owns the port
  assign deq = pop || (!empty && !vld[head]);
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) if (vld[i]) pending[rd_q[i]] = 1'b1;
    pending[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (kill_en && rd_q[i] == kill_rd) vld[i] <= 1'b0;
      if (deq) vld[head] <= 1'b0;
      if (push) vld[tail] <= 1'b1;
      head <= deq ? head + AW'(1) : head;
      tail <= push ? tail + AW'(1) : tail;
      occupancy <= occupancy + CW'(push) - CW'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail] <= push_rd;
      wd_q[tail] <= push_wd;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges ALU and load write-backs onto the single register-file write port
module wb_port_arbiter import rv_core_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0]  alu_wd,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_ADDR_W-1:0]  ld_rd,
  input  logic [DATA_WIDTH-1:0]  ld_wd,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_rd,
  output logic [DATA_WIDTH-1:0]  rf_wd,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] occupancy
);
  logic alu_win, pop, bypass, push, head_valid, full, empty;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_wd;
  assign ld_ready = !full;
  assign alu_win = alu_valid && alu_rd != '0;
  assign pop = !alu_win && head_valid;
  assign bypass = !alu_win && empty && ld_valid && ld_rd != '0;
  // loads to x0 are accepted but never stored
  assign push = ld_valid && ld_ready && ld_rd != '0 && !bypass;
  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_rd(ld_rd), .push_wd(ld_wd),
    .pop(pop), .kill_en(alu_win), .kill_rd(alu_rd),
    .head_valid(head_valid), .head_rd(head_rd), .head_wd(head_wd),
    .full(full), .empty(empty), .occupancy(occupancy), .pending(pending)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= alu_win || pop || bypass;
      rf_rd <= alu_win ? alu_rd : pop ? head_rd : bypass ? ld_rd : '0;
      rf_wd <= alu_win ? alu_wd : pop ? head_wd : bypass ? ld_wd : '0;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scoreboard bench for the write-back port arbiter
module tb_wb_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, ld_valid = 0, ld_ready, rf_we;
  logic [4:0] alu_rd = 0, ld_rd = 0, rf_rd;
  logic [31:0] alu_wd = 0, ld_wd = 0, rf_wd, pending;
  logic [1:0] occupancy;
  logic [36:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  wb_port_arbiter #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pending(pending), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    ld_valid = lv; ld_rd = lrd; ld_wd = lwd;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=0x%0h expected no write", rf_rd, rf_wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_rd} ^ {rf_wd}, {27'd0, e[36:32]} ^ e[31:0]);
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, e[36:32]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_we", {31'd0, rf_we}, 0);
    chk("reset_occ", {30'd0, occupancy}, 0);
    chk("reset_pending", pending, 0);
    step(); step();
    rst_n = 1;
    #1;
    chk("ready_after_reset", {31'd0, ld_ready}, 1);
    step();
    // collision: ALU first, load buffered one cycle
    drive(1, 5, 32'h11, 1, 6, 32'hAA);
    expect_wr(5, 32'h11); expect_wr(6, 32'hAA);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("coll_pending", pending, 32'h40);
    chk("coll_occ", {30'd0, occupancy}, 1);
    step();
    chk("coll_pending_clr", pending, 0);
    chk("coll_occ_clr", {30'd0, occupancy}, 0);
    // bypass
    drive(0, 0, 0, 1, 7, 32'h1234);
    expect_wr(7, 32'h1234);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("byp_occ", {30'd0, occupancy}, 0);
    chk("byp_pending", pending, 0);
    step();
    // full / backpressure
    drive(1, 1, 32'hA0, 1, 2, 32'h22); expect_wr(1, 32'hA0);
    step();
    chk("full_occ1", {30'd0, occupancy}, 1);
    drive(1, 1, 32'hA1, 1, 3, 32'h33); expect_wr(1, 32'hA1);
    chk("full_ready1", {31'd0, ld_ready}, 1);
    step();
    chk("full_occ2", {30'd0, occupancy}, 2);
    chk("full_pending", pending, 32'h0C);
    drive(1, 1, 32'hA2, 1, 4, 32'h44); expect_wr(1, 32'hA2);
    chk("full_ready0", {31'd0, ld_ready}, 0);
    step();
    chk("full_held_occ", {30'd0, occupancy}, 2);
    drive(0, 0, 0, 1, 4, 32'h44); expect_wr(2, 32'h22);
    chk("full_ready0b", {31'd0, ld_ready}, 0);
    step();
    chk("drain_occ1", {30'd0, occupancy}, 1);
    chk("drain_ready", {31'd0, ld_ready}, 1);
    expect_wr(3, 32'h33);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("popush_occ", {30'd0, occupancy}, 1);
    chk("popush_pending", pending, 32'h10);
    expect_wr(4, 32'h44);
    step();
    chk("drain_empty", {30'd0, occupancy}, 0);
    step();
    // WAW kill
    drive(1, 1, 32'hB0, 1, 9, 32'h1); expect_wr(1, 32'hB0);
    step();
    chk("waw_pending", pending, 32'h200);
    drive(1, 9, 32'h2, 0, 0, 0); expect_wr(9, 32'h2);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("waw_pending_clr", pending, 0);
    chk("waw_occ_killed", {30'd0, occupancy}, 1);
    step();
    chk("waw_dropped", {30'd0, occupancy}, 0);
    step();
    // x0 handling
    drive(1, 1, 32'hC0, 1, 3, 32'h5); expect_wr(1, 32'hC0);
    step();
    drive(1, 0, 32'hFF, 1, 0, 32'h7); expect_wr(3, 32'h5);
    chk("x0_ready", {31'd0, ld_ready}, 1);
    step();
    chk("x0_occ", {30'd0, occupancy}, 0);
    chk("x0_pending", pending, 0);
    drive(0, 0, 0, 1, 0, 32'h7);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_ld_occ", {30'd0, occupancy}, 0);
    step();
    // reset mid-traffic
    drive(1, 1, 32'hD0, 1, 10, 32'hE); expect_wr(1, 32'hD0);
    step();
    chk("pre_rst_pending", pending, 32'h400);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_we", {31'd0, rf_we}, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_occ", {30'd0, occupancy}, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1;
    #1;
    chk("post_rst_ready", {31'd0, ld_ready}, 1);
    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
